z_result_stage: RTL and testbench

//  ALU output stage: captures 64-bit ALU result (shift/rotate, add, mul, div) into
//  Z register pair (Z_high/Z_low), waits for multi-cycle ops via start/done

---
 rtl/z_result_stage.sv | 112 +++++++++++
 tb/tb_z_result_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/z_result_stage.sv
// ALU output stage: captures ALU results into the Z register pair, handshakes
// with multi-cycle units, and drives either Z half onto the shared datapath bus.
module z_result_stage #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               Zin,
   input  logic               op_multi,
   output logic               alu_start,
   input  logic               alu_done,
   input  logic [2*WIDTH-1:0] alu_result,
   input  logic               Zhighout,
   input  logic               Zlowout,
   output logic [WIDTH-1:0]   bus_out,
   output logic [WIDTH-1:0]   z_high,
   output logic [WIDTH-1:0]   z_low,
   output logic               z_valid,
   output logic               busy,
   output logic               flag_zero,
   output logic               flag_neg,
   output logic               err
);

   typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

   state_t           state;
   state_t           stateNext;
   logic [CNT_W-1:0] waitCount;
   logic             doCapture;
   logic             doStart;
   logic             doTimeout;
   logic             selConflict;

   assign z_valid     = (state == FULL);
   assign busy        = (state == WAIT);
   assign selConflict = Zhighout & Zlowout;

   // A completion arriving on the final wait cycle takes precedence over the abort.
   always_comb begin
      stateNext = state;
      doCapture = 1'b0;
      doStart   = 1'b0;
      doTimeout = 1'b0;
      case (state)
         IDLE, FULL: begin
            if (Zin) begin
               if (op_multi) begin
                  stateNext = WAIT;
                  doStart   = 1'b1;
               end else begin
                  stateNext = FULL;
                  doCapture = 1'b1;
               end
            end
         end
         WAIT: begin
            if (alu_done) begin
               stateNext = FULL;
               doCapture = 1'b1;
            end else if (waitCount == CNT_W'(TIMEOUT - 1)) begin
               stateNext = IDLE;
               doTimeout = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         alu_start <= 1'b0;
         waitCount <= '0;
         z_high    <= '0;
         z_low     <= '0;
         flag_zero <= 1'b0;
         flag_neg  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= stateNext;
         alu_start <= doStart;
         if (doStart) begin
            waitCount <= '0;
         end else if (state == WAIT) begin
            waitCount <= waitCount + CNT_W'(1);
         end
         if (doCapture) begin
            z_high    <= alu_result[2*WIDTH-1:WIDTH];
            z_low     <= alu_result[WIDTH-1:0];
            flag_zero <= (alu_result[WIDTH-1:0] == '0);
            flag_neg  <= alu_result[WIDTH-1];
         end
         if (doTimeout || selConflict) begin
            err <= 1'b1;
         end
      end
   end

   // Low half wins when both selects are asserted; the conflict is flagged via err.
   always_comb begin
      bus_out = '0;
      if (Zlowout) begin
         bus_out = z_low;
      end else if (Zhighout) begin
         bus_out = z_high;
      end
   end

endmodule

// File: tb/tb_z_result_stage.sv
// Directed self-checking bench for z_result_stage with hand-computed expectations.
module tb_z_result_stage;

   logic        clk = 1'b0;
   logic        clr;
   logic        Zin;
   logic        op_multi;
   logic        alu_start;
   logic        alu_done;
   logic [63:0] alu_result;
   logic        Zhighout;
   logic        Zlowout;
   logic [31:0] bus_out;
   logic [31:0] z_high;
   logic [31:0] z_low;
   logic        z_valid;
   logic        busy;
   logic        flag_zero;
   logic        flag_neg;
   logic        err;

   int checkCount = 0;
   int passCount  = 0;

   z_result_stage #(.WIDTH(32), .TIMEOUT(64), .CNT_W(7)) dut (
      .clk(clk), .clr(clr), .Zin(Zin), .op_multi(op_multi),
      .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
      .Zhighout(Zhighout), .Zlowout(Zlowout), .bus_out(bus_out),
      .z_high(z_high), .z_low(z_low), .z_valid(z_valid), .busy(busy),
      .flag_zero(flag_zero), .flag_neg(flag_neg), .err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic zin, input logic multi, input logic done, input logic [63:0] result);
      Zin        = zin;
      op_multi   = multi;
      alu_done   = done;
      alu_result = result;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      clr = 1'b0;
      checkOutput("rst_zhigh", z_high, 0);
      checkOutput("rst_zlow", z_low, 0);
      checkOutput("rst_valid", z_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_start", alu_start, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_flags", {flag_zero, flag_neg}, 0);

      // Single-cycle capture; bus read during the capture cycle sees the old value
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0000_0000_8000_0000);
      Zlowout = 1'b1;
      #2;
      checkOutput("bus_pre_capture", bus_out, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("sc_zlow", z_low, 64'h8000_0000);
      checkOutput("sc_zhigh", z_high, 0);
      checkOutput("sc_valid", z_valid, 1);
      checkOutput("sc_neg", flag_neg, 1);
      checkOutput("sc_zero", flag_zero, 0);
      checkOutput("sc_bus_low", bus_out, 64'h8000_0000);
      Zlowout = 1'b0;
      #1;
      checkOutput("bus_none", bus_out, 0);

      // Multi-cycle op completing 5 cycles after the request
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("mc_start_hi", alu_start, 1);
      checkOutput("mc_valid_lo", z_valid, 0);
      checkOutput("mc_stale_zlow", z_low, 64'h8000_0000);
      checkOutput("mc_busy0", busy, 1);
      for (int i = 1; i < 5; i++) begin
         tick();
         checkOutput($sformatf("mc_busy%0d", i), busy, 1);
         checkOutput($sformatf("mc_start_lo%0d", i), alu_start, 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("mc_busy_done", busy, 0);
      checkOutput("mc_valid", z_valid, 1);
      checkOutput("mc_zhigh", z_high, 1);
      checkOutput("mc_zlow", z_low, 64'hFFFF_FFFE);
      Zhighout = 1'b1;
      #1;
      checkOutput("mc_bus_high", bus_out, 1);
      Zhighout = 1'b0;

      // Zin during WAIT is ignored
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 64'hDEAD);
      tick();
      checkOutput("ign_busy", busy, 1);
      checkOutput("ign_zlow", z_low, 64'hFFFF_FFFE);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'hDEAD);
      tick();
      checkOutput("ign_norestart", alu_start, 0);
      checkOutput("ign_valid", z_valid, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0000_1234_5678);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("ign_done_zlow", z_low, 64'h1234_5678);

      // alu_done on the last permitted wait cycle wins over timeout
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 1; i < 64; i++) tick();
      checkOutput("edge_busy63", busy, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0042);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("edge_valid", z_valid, 1);
      checkOutput("edge_zlow", z_low, 64'h42);
      checkOutput("edge_noerr", err, 0);

      // Timeout after TIMEOUT cycles, then a late alu_done is ignored
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      for (int i = 1; i < 64; i++) tick();
      checkOutput("to_busy63", busy, 1);
      checkOutput("to_err_pre", err, 0);
      tick();
      checkOutput("to_busy", busy, 0);
      checkOutput("to_err", err, 1);
      checkOutput("to_valid", z_valid, 0);
      checkOutput("to_zlow", z_low, 64'h42);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_BEEF);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("late_zlow", z_low, 64'h42);
      checkOutput("late_valid", z_valid, 0);
      checkOutput("late_err_sticky", err, 1);

      // clr in the middle of WAIT
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      tick();
      tick();
      clr = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_0099);
      tick();
      clr = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("clr_busy", busy, 0);
      checkOutput("clr_valid", z_valid, 0);
      checkOutput("clr_z", {z_high, z_low}, 0);
      checkOutput("clr_err", err, 0);

      // Zero result sets flag_zero
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("zero_flag", {flag_zero, flag_neg}, 2'b10);
      checkOutput("zero_valid", z_valid, 1);

      // Bus select conflict
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0000_0007_0000_0005);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
      checkOutput("cf_zhigh", z_high, 7);
      Zhighout = 1'b1;
      Zlowout  = 1'b1;
      #1;
      checkOutput("cf_bus", bus_out, 5);
      checkOutput("cf_err_pre", err, 0);
      tick();
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      #1;
      checkOutput("cf_err", err, 1);
      checkOutput("cf_bus_none", bus_out, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
